// File: rtl/noise_pkg.sv
// Shared constants and pixel type for the noise-detection datapath.
package noise_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_IMG_WIDTH  = 64;
  localparam int DEFAULT_IMG_HEIGHT = 64;
  localparam int WIN_SIZE           = 3;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// One-line pixel store: combinational read at addr, write on the clock edge,
// so a same-cycle read returns the previous line's value.
module line_buffer
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
)
(
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator with two line buffers; emits only full-interior windows.
// Optional macro WIN_POS_EN adds win_row/win_col centre-coordinate outputs.
module window3x3_gen
  import noise_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  win_valid,
  output logic                  win_eof,
  output logic [DATA_WIDTH-1:0] w1,
  output logic [DATA_WIDTH-1:0] w2,
  output logic [DATA_WIDTH-1:0] w3,
  output logic [DATA_WIDTH-1:0] w4,
  output logic [DATA_WIDTH-1:0] w5,
  output logic [DATA_WIDTH-1:0] w6,
  output logic [DATA_WIDTH-1:0] w7,
  output logic [DATA_WIDTH-1:0] w8,
  output logic [DATA_WIDTH-1:0] w9
`ifdef WIN_POS_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam int WN = WIN_SIZE * WIN_SIZE;

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [DATA_WIDTH-1:0] top, mid;
  logic [DATA_WIDTH-1:0] win [WN];
  logic interior;

  // A start-of-frame pixel is always (0,0), overriding whatever the counters say.
  always_comb begin
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    interior = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) lb1 (
    .clk  (clk),
    .we   (in_valid),
    .addr (cur_col),
    .wdata(in_data),
    .rdata(mid)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) lb0 (
    .clk  (clk),
    .we   (in_valid),
    .addr (cur_col),
    .wdata(mid),
    .rdata(top)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WN; i++) win[i] <= '0;
    end else if (in_valid) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= top;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= mid;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
    end else begin
      win_valid <= in_valid && interior;
      win_eof   <= in_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

`ifdef WIN_POS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_row <= '0;
      win_col <= '0;
    end else if (in_valid && interior) begin
      win_row <= cur_row - RW'(1);
      win_col <= cur_col - CW'(1);
    end
  end
`endif

  assign w1 = win[0];
  assign w2 = win[1];
  assign w3 = win[2];
  assign w4 = win[3];
  assign w5 = win[4];
  assign w6 = win[5];
  assign w7 = win[6];
  assign w8 = win[7];
  assign w9 = win[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 5x4 image; expected windows derived from pixel = base+10*r+c.
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CB = $clog2(W);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic win_valid, win_eof;
  logic [DW-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
`ifdef WIN_POS_EN
  logic [$clog2(H)-1:0] win_row;
  logic [CB-1:0] win_col;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int win_count = 0;

  window3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .win_valid(win_valid),
    .win_eof  (win_eof),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9)
`ifdef WIN_POS_EN
    ,
    .win_row  (win_row),
    .win_col  (win_col)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  function automatic logic [71:0] dutWin();
    return {w1, w2, w3, w4, w5, w6, w7, w8, w9};
  endfunction

  // Window centred on (cr,cc) of a frame whose pixels are base+10*r+c.
  function automatic logic [71:0] expWin(input int base, input int cr, input int cc);
    logic [71:0] res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res = {res[63:0], 8'(base + 10 * (cr - 1 + i) + (cc - 1 + j))};
    return res;
  endfunction

  task automatic applyStimulus(input logic v, input logic sof, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic pixelCheck(input int base, input int r, input int c, input logic sof, input string tag);
    logic exp_v;
    applyStimulus(1'b1, sof, 8'(base + 10 * r + c));
    exp_v = (r >= 2) && (c >= 2);
    if (win_valid) win_count++;
    checkOutput($sformatf("%s valid(%0d,%0d)", tag, r, c), win_valid, exp_v);
    checkOutput($sformatf("%s eof(%0d,%0d)", tag, r, c), win_eof, (r == H - 1) && (c == W - 1));
    if (exp_v) begin
      checkOutput($sformatf("%s win(%0d,%0d)", tag, r, c), dutWin(), expWin(base, r - 1, c - 1));
`ifdef WIN_POS_EN
      checkOutput($sformatf("%s pos(%0d,%0d)", tag, r, c), {win_row, win_col},
                  ((r - 1) << CB) | (c - 1));
`endif
    end
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'b0, 8'hA5);
    checkOutput({tag, " idle valid"}, win_valid, 1'b0);
  endtask

  task automatic sendFrame(input int base, input bit gaps, input bit sof_first, input string tag);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) begin
          int n = $urandom_range(0, 2);
          for (int k = 0; k < n; k++) idleCycle(tag);
        end
        pixelCheck(base, r, c, sof_first && r == 0 && c == 0, tag);
      end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid", win_valid, 1'b0);
    checkOutput("reset eof", win_eof, 1'b0);
    checkOutput("reset win", dutWin(), 72'h0);
    rst_n = 1'b1;

    // Test 1: continuous frame, then the last window must hold through an idle cycle
    win_count = 0;
    sendFrame(0, 1'b0, 1'b1, "t1");
    checkOutput("t1 count", win_count, 6);
    idleCycle("t1");
    checkOutput("t1 hold", dutWin(), 72'h0C0D0E_161718_202122);

    // Test 2: same frame with random gaps
    win_count = 0;
    sendFrame(0, 1'b1, 1'b1, "t2");
    checkOutput("t2 count", win_count, 6);

    // Test 3: back-to-back frames, second relies on the counter wrap
    win_count = 0;
    sendFrame(0, 1'b0, 1'b1, "t3a");
    sendFrame(100, 1'b0, 1'b0, "t3b");
    checkOutput("t3 count", win_count, 12);

    // Test 4: restart at pixel (2,3) of a partial frame
    win_count = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 3) pixelCheck(0, r, c, r == 0 && c == 0, "t4p");
    sendFrame(0, 1'b0, 1'b1, "t4");
    checkOutput("t4 count", win_count, 7);

    // Test 5: reset after row 2, then restart without sof
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        pixelCheck(0, r, c, r == 0 && c == 0, "t5p");
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    checkOutput("t5 rst valid", win_valid, 1'b0);
    checkOutput("t5 rst eof", win_eof, 1'b0);
    checkOutput("t5 rst win", dutWin(), 72'h0);
`ifdef WIN_POS_EN
    checkOutput("t5 rst pos", {win_row, win_col}, 0);
`endif
    win_count = 0;
    sendFrame(0, 1'b0, 1'b0, "t5");
    checkOutput("t5 count", win_count, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
